// File: rtl/led_bar_pkg.sv
// Shared types and helpers for the LED bar meter: peak FSM states, level width, thermometer coding.
package led_bar_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        DECAY = 2'd2
    } peak_state_t;

    localparam int LEDS_DEF = 10;
    localparam int LEVEL_W  = $clog2(LEDS_DEF + 1);
    // Widest LED row the helper functions can code; callers slice down to their LEDS.
    localparam int LEDS_MAX = 64;

    function automatic logic [LEDS_MAX-1:0] therm(input int level);
        logic [LEDS_MAX-1:0] t;
        t = '0;
        for (int i = 0; i < LEDS_MAX; i++) begin
            if (i < level) t[i] = 1'b1;
        end
        return t;
    endfunction

    function automatic logic [LEDS_MAX-1:0] one_hot_level(input int level);
        logic [LEDS_MAX-1:0] t;
        t = '0;
        for (int i = 0; i < LEDS_MAX; i++) begin
            if (i == level - 1) t[i] = 1'b1;
        end
        return t;
    endfunction

endpackage

// File: rtl/led_bar_peak_fsm.sv
// Peak-hold tracker: captures new peaks, holds them HOLD_CYCLES, then decays one LED per DECAY_CYCLES.
module led_bar_peak_fsm
    import led_bar_pkg::*;
#(
    parameter int LEDS         = 10,
    parameter int HOLD_CYCLES  = 1000,
    parameter int DECAY_CYCLES = 100
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       capture_in,
    input  logic [$clog2(LEDS+1)-1:0]  level_in,
    output logic [$clog2(LEDS+1)-1:0]  peak_out
);

    localparam int PEAK_W  = $clog2(LEDS + 1);
    localparam int CNT_MAX = (HOLD_CYCLES > DECAY_CYCLES) ? HOLD_CYCLES : DECAY_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] DECAY_LAST = CNT_W'(DECAY_CYCLES - 1);

    peak_state_t         state_q, state_d;
    logic [PEAK_W-1:0]   peak_q, peak_d;
    logic [CNT_W-1:0]    hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0]    decay_cnt_q, decay_cnt_d;
    logic                take;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            peak_q      <= '0;
            hold_cnt_q  <= '0;
            decay_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            peak_q      <= peak_d;
            hold_cnt_q  <= hold_cnt_d;
            decay_cnt_q <= decay_cnt_d;
        end
    end

    // A qualifying capture overrides whatever hold expiry or decay step happens on the same edge.
    assign take = capture_in && (level_in != '0) && (level_in >= peak_q);

    always_comb begin
        state_d     = state_q;
        peak_d      = peak_q;
        hold_cnt_d  = hold_cnt_q;
        decay_cnt_d = decay_cnt_q;

        case (state_q)
            IDLE: begin
                peak_d      = '0;
                hold_cnt_d  = '0;
                decay_cnt_d = '0;
            end
            HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d     = DECAY;
                    hold_cnt_d  = '0;
                    decay_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            DECAY: begin
                if (decay_cnt_q == DECAY_LAST) begin
                    decay_cnt_d = '0;
                    peak_d      = peak_q - PEAK_W'(1);
                    if (peak_q == PEAK_W'(1)) state_d = IDLE;
                end else begin
                    decay_cnt_d = decay_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d     = IDLE;
                peak_d      = '0;
                hold_cnt_d  = '0;
                decay_cnt_d = '0;
            end
        endcase

        if (take) begin
            state_d     = HOLD;
            peak_d      = level_in;
            hold_cnt_d  = '0;
            decay_cnt_d = '0;
        end
    end

    always_comb begin
        peak_out = peak_q;
    end

endmodule

// File: rtl/led_bar_meter.sv
// LED bar-graph meter with peak-hold dot. Optional LED_BAR_DOT_MODE_EN adds dot_mode_in (single-LED bar).
module led_bar_meter
    import led_bar_pkg::*;
#(
    parameter int DATA_W       = 10,
    parameter int LEDS         = 10,
    parameter int HOLD_CYCLES  = 1000,
    parameter int DECAY_CYCLES = 100
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic [DATA_W-1:0]          sample_in,
    input  logic                       sample_valid_in,
`ifdef LED_BAR_DOT_MODE_EN
    input  logic                       dot_mode_in,
`endif
    output logic [LEDS-1:0]            led_out,
    output logic [$clog2(LEDS+1)-1:0]  peak_level_out
);

    localparam int PEAK_W = $clog2(LEDS + 1);
    localparam int PROD_W = DATA_W + PEAK_W;

    logic [PROD_W-1:0]  product;
    logic [PEAK_W-1:0]  level;
    logic [LEDS-1:0]    bar_d, bar_q;
    logic [LEDS-1:0]    dot;
    logic [PEAK_W-1:0]  peak;

    // Scaling by LEDS+1 then dropping DATA_W bits maps full scale onto 0..LEDS without a divider.
    assign product = PROD_W'(sample_in) * PROD_W'(LEDS + 1);
    assign level   = PEAK_W'(product >> DATA_W);

`ifdef LED_BAR_DOT_MODE_EN
    always_comb begin
        if (dot_mode_in) bar_d = LEDS'(one_hot_level(int'(level)));
        else             bar_d = LEDS'(therm(int'(level)));
    end
`else
    always_comb begin
        bar_d = LEDS'(therm(int'(level)));
    end
`endif

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)               bar_q <= '0;
        else if (sample_valid_in) bar_q <= bar_d;
    end

    led_bar_peak_fsm #(
        .LEDS         (LEDS),
        .HOLD_CYCLES  (HOLD_CYCLES),
        .DECAY_CYCLES (DECAY_CYCLES)
    ) u_peak (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .capture_in (sample_valid_in),
        .level_in   (level),
        .peak_out   (peak)
    );

    // Both terms come straight from registers, so bar and dot change together on the peak edge.
    always_comb begin
        dot = LEDS'(one_hot_level(int'(peak)));
    end

    assign led_out        = bar_q | dot;
    assign peak_level_out = peak;

endmodule

// File: tb/tb_led_bar_meter.sv
// Scoreboard bench for led_bar_meter: timeline-based peak model, randomized and directed stimulus.
module tb_led_bar_meter;

    localparam int DATA_W = 10;
    localparam int LEDS   = 10;
    localparam int HOLD   = 8;
    localparam int DECAY  = 4;
    localparam int PW     = $clog2(LEDS + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] sample;
    logic              valid;
    logic [LEDS-1:0]   led;
    logic [PW-1:0]     peak_level;

    typedef struct {
        int led;
        int pk;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;

    // Model state: the peak is a pure function of the capture edge and the elapsed edges.
    int edge_no   = 0;
    int cap_edge  = 0;
    int cap_level = 0;
    int bar_level = 0;

    always #5 clk = ~clk;

    led_bar_meter #(
        .DATA_W       (DATA_W),
        .LEDS         (LEDS),
        .HOLD_CYCLES  (HOLD),
        .DECAY_CYCLES (DECAY)
    ) dut (
        .clk_in          (clk),
        .rst_in          (rst),
        .sample_in       (sample),
        .sample_valid_in (valid),
`ifdef LED_BAR_DOT_MODE_EN
        .dot_mode_in     (1'b0),
`endif
        .led_out         (led),
        .peak_level_out  (peak_level)
    );

    function automatic int lvl_of(int s);
        return (s * (LEDS + 1)) >> DATA_W;
    endfunction

    function automatic int peak_at(int e);
        int el, p;
        if (cap_level == 0) return 0;
        el = e - cap_edge;
        if (el < HOLD) return cap_level;
        p = cap_level - (el - HOLD) / DECAY;
        return (p < 0) ? 0 : p;
    endfunction

    function automatic int led_of(int bl, int pk);
        int v;
        v = (1 << bl) - 1;
        if (pk > 0) v = v | (1 << (pk - 1));
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // One clock: drive inputs, let the edge happen, record what the DUT must show afterwards.
    task automatic cyc(input logic v, input int s);
        int l, pk;
        valid  = v;
        sample = DATA_W'(s);
        @(posedge clk);
        if (!rst) begin
            edge_no++;
            if (v) begin
                l = lvl_of(s);
                bar_level = l;
                if (l > 0 && l >= peak_at(edge_no - 1)) begin
                    cap_level = l;
                    cap_edge  = edge_no;
                end
            end
            pk = peak_at(edge_no);
            q.push_back('{led: led_of(bar_level, pk), pk: pk});
        end
        #1;
    endtask

    task automatic async_reset();
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_led", int'(led), 0);
        chk("rst_peak", int'(peak_level), 0);
        cap_level = 0;
        bar_level = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("led_out", int'(led), e.led);
            chk("peak_level", int'(peak_level), e.pk);
        end
    end

    initial begin
        rst    = 1'b1;
        valid  = 1'b0;
        sample = '0;
        #3;
        chk("por_led", int'(led), 0);
        chk("por_peak", int'(peak_level), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Idle after reset.
        repeat (4) cyc(1'b0, 0);

        // Thresholds.
        cyc(1'b1, 93);
        cyc(1'b1, 94);
        cyc(1'b1, 512);
        cyc(1'b1, 1023);

        // Full hold and decay to idle with zero samples.
        cyc(1'b1, 1023);
        repeat (60) cyc(1'b1, 0);

        // Lower sample ignored while holding peak 9.
        cyc(1'b1, 838);
        repeat (2) cyc(1'b0, 0);
        cyc(1'b1, 256);
        repeat (50) cyc(1'b0, 0);

        // Capture on the decay-step edge at peak 6.
        cyc(1'b1, 1023);
        repeat (27) cyc(1'b0, 0);
        cyc(1'b1, 652);
        repeat (40) cyc(1'b0, 0);

        // Asynchronous reset in the middle of a hold.
        cyc(1'b1, 1023);
        repeat (3) cyc(1'b0, 0);
        async_reset();
        repeat (2) cyc(1'b0, 0);
        cyc(1'b1, 1023);
        repeat (20) cyc(1'b1, 0);

        // Randomized traffic: sparse valids let holds and decays play out between captures.
        for (int i = 0; i < 600; i++) begin
            logic v;
            int   s;
            v = ($urandom_range(0, 9) < 3);
            case ($urandom_range(0, 3))
                0:       s = 0;
                1:       s = $urandom_range(900, 1023);
                default: s = $urandom_range(0, 1023);
            endcase
            cyc(v, s);
            if ($urandom_range(0, 299) == 0) async_reset();
        end
        repeat (3) cyc(1'b0, 0);

        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
